// File: rtl/shifter_pkg.sv
// Shared types and defaults for the shift-unit datapath blocks.
package shifter_pkg;

    typedef enum logic {DIR_LSB_FIRST = 1'b0, DIR_MSB_FIRST = 1'b1} shift_dir_t;
    typedef enum logic {IDLE, COLLECT} deser_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: one bit per handshake into a WIDTH-bit word, one-entry output register.
// Word valid the cycle after its last bit; bit_ready drops only on a final bit while the output is held.
module shift_deserializer
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             msb_first,
    input  logic             clear,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    deser_state_t     state;
    shift_dir_t       dir;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             eff_msb;
    logic             last_bit;
    logic             bit_take;
    logic             word_take;

    assign last_bit  = (count == LAST);
    assign bit_ready = !rst && !clear && (!last_bit || !word_valid || word_ready);
    assign bit_take  = bit_valid && bit_ready;
    assign word_take = word_valid && word_ready;

    // The first bit of a word follows msb_first live; later bits use the latched direction.
    always_comb begin
        eff_msb = (state == IDLE) ? msb_first : (dir == DIR_MSB_FIRST);
        sr_next = sr;
        if (eff_msb) begin
            sr_next = {sr[WIDTH-2:0], bit_in};
        end else begin
            sr_next = {bit_in, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir        <= DIR_MSB_FIRST;
            count      <= '0;
            sr         <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            if (word_take) begin
                word_valid <= 1'b0;
            end
            if (clear) begin
                state <= IDLE;
                count <= '0;
                sr    <= '0;
            end else if (bit_take) begin
                sr <= sr_next;
                if (state == IDLE) begin
                    dir <= shift_dir_t'(msb_first);
                end
                if (last_bit) begin
                    // Load overrides a same-cycle drain, so back-to-back words see no bubble.
                    word_out   <= sr_next;
                    word_valid <= 1'b1;
                    count      <= '0;
                    state      <= IDLE;
                end else begin
                    count <= count + CW'(1);
                    state <= COLLECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer against a queue-based word model.
module tb_shift_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_valid;
    logic         bit_in;
    logic         bit_ready;
    logic         msb_first;
    logic         clear;
    logic         word_valid;
    logic         word_ready;
    logic [W-1:0] word_out;

    int checks = 0;
    int errors = 0;

    bit           m_q[$];
    bit           m_dir;
    bit           m_vld;
    logic [W-1:0] m_word;

    always #5 clk = ~clk;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .msb_first (msb_first),
        .clear     (clear),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_out  (word_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First received bit lands at the MSB for MSB-first, at the LSB for LSB-first.
    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_dir) w[W-1-i] = m_q[i];
            else       w[i]     = m_q[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_dir  = 1'b1;
        m_vld  = 1'b0;
        m_word = '0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input bit v, input bit b, input bit m, input bit c, input bit r);
        bit exp_rdy;
        bit acc;
        bit_valid  = v;
        bit_in     = b;
        msb_first  = m;
        clear      = c;
        word_ready = r;
        #2;
        exp_rdy = !c && ((m_q.size() != W-1) || !m_vld || r);
        check("bit_ready", bit_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (m_vld && r) m_vld = 1'b0;
        if (c) begin
            m_q.delete();
        end else if (acc) begin
            if (m_q.size() == 0) m_dir = m;
            m_q.push_back(b);
            if (m_q.size() == W) begin
                m_word = pack_word();
                m_vld  = 1'b1;
                m_q.delete();
            end
        end
        check("word_valid", word_valid, m_vld);
        check("word_out", word_out, m_word);
    endtask

    // bits[W-1] is sent first.
    task automatic send_word(input logic [W-1:0] bits, input bit m, input bit r);
        for (int i = W-1; i >= 0; i--) step(1'b1, bits[i], m, 1'b0, r);
    endtask

    initial begin
        rst        = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        msb_first  = 1'b1;
        clear      = 1'b0;
        word_ready = 1'b1;
        model_reset();
        #1;
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_out", word_out, '0);
        check("rst_bit_ready", bit_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_word(4'b1011, 1'b1, 1'b1);
        check("msb_word", word_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("msb_one_cycle", word_valid, 1'b0);

        send_word(4'b1011, 1'b0, 1'b1);
        check("lsb_word", word_out, 4'b1101);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        send_word(4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, (i != 0), 1'b1, 1'b0, 1'b0);
        check("bp_held", word_out, 4'b1011);
        bit_valid = 1'b1; bit_in = 1'b0; word_ready = 1'b0;
        #2;
        check("bp_stall", bit_ready, 1'b0);
        @(posedge clk);
        #1;
        check("bp_held2", word_out, 4'b1011);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("bp_next_word", word_out, 4'b0110);
        check("bp_no_bubble", word_valid, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_no_word", word_valid, 1'b0);
        send_word(4'b0011, 1'b1, 1'b1);
        check("clear_word", word_out, 4'b0011);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_word_valid", word_valid, 1'b0);
        check("arst_word_out", word_out, '0);
        check("arst_bit_ready", bit_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(4'b1110, 1'b1, 1'b1);
        check("post_rst_word", word_out, 4'b1110);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("dir_latch_word", word_out, 4'b1001);

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
